// File: rtl/pipeline_ctrl_if.sv
// Purpose : bundles the request side and the control outputs of pipeline_ctrl.
// Latency : n/a (wires only).
// Backpressure: rdy_in is the global freeze. flush_req_in is held until flush_ack_out.
//
// Signals (controller view, slave modport):
//   rdy_in, stallreq_in, flush_req_in, cnt_clr_in                  inputs from the core
//   stall_out, flush_out, flush_ack_out, hang_out, stall_cycles_out,
//   flush_count_out                                                outputs to the core
interface pipeline_ctrl_if #(
    parameter int STAGES = 6,
    parameter int CNT_W  = 16
);
    logic              rdy_in;
    logic [STAGES-1:0] stallreq_in;
    logic              flush_req_in;
    logic              cnt_clr_in;
    logic [STAGES-1:0] stall_out;
    logic [STAGES-1:0] flush_out;
    logic              flush_ack_out;
    logic              hang_out;
    logic [CNT_W-1:0]  stall_cycles_out;
    logic [CNT_W-1:0]  flush_count_out;

    // Core side: raises requests and consumes the stall/flush controls.
    modport master (
        output rdy_in, stallreq_in, flush_req_in, cnt_clr_in,
        input  stall_out, flush_out, flush_ack_out, hang_out,
               stall_cycles_out, flush_count_out
    );

    // Controller side.
    modport slave (
        input  rdy_in, stallreq_in, flush_req_in, cnt_clr_in,
        output stall_out, flush_out, flush_ack_out, hang_out,
               stall_cycles_out, flush_count_out
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Purpose : pipeline stall/flush controller (stall priority, flush sequencer, watchdog, perf counters).
// Latency : stall_out 0 cycles. flush_out/flush_ack_out 1 cycle after accept. Counters 1 cycle.
// Backpressure: rdy_in=0 stalls every stage and freezes all state. flush_req_in is held by the requester until acked.
//
// Ports: clk_in (rising edge), rst_in (async, active low).
//        bus is pipeline_ctrl_if.slave; see the interface file for the signal list.
module pipeline_ctrl #(
    parameter int STAGES      = 6,
    parameter int FLUSH_STAGE = 3,
    parameter int FLUSH_LEN   = 1,
    parameter int WDOG_LIMIT  = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    pipeline_ctrl_if.slave      bus
);

    localparam int LEN_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    // Stages younger than the branch-resolving stage; these are squashed by a flush.
    localparam logic [STAGES-1:0] FLUSH_BITS =
        {{(STAGES-FLUSH_STAGE){1'b0}}, {FLUSH_STAGE{1'b1}}};

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;      // remaining flush cycles minus one
    logic              first_q, first_nxt;  // ack not yet given for this flush
    logic              accept;
    logic              blocked;
    logic [STAGES-1:0] req_masked;
    logic [STAGES-1:0] stall_therm;
    logic [STAGES-1:0] stall;
    logic              stalled;
    logic              hang;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // Older stages than the flushing stage must drain first, so any request above
    // FLUSH_STAGE holds the flush off. A request at FLUSH_STAGE does not.
    assign blocked = |bus.stallreq_in[STAGES-1:FLUSH_STAGE+1];

    // Stall priority: the oldest requesting stage stalls itself and every younger
    // stage behind it. During FLUSH the younger stages are being squashed, so
    // their requests are meaningless and are masked off.
    always_comb begin
        logic acc;
        req_masked  = bus.stallreq_in & ((state_q == FLUSH) ? ~FLUSH_BITS : {STAGES{1'b1}});
        stall_therm = '0;
        acc         = 1'b0;
        for (int i = STAGES-1; i >= 0; i--) begin
            acc            = acc | req_masked[i];
            stall_therm[i] = acc;
        end
        if (!rst_in) begin
            stall = '0;
        end else if (!bus.rdy_in) begin
            stall = {STAGES{1'b1}};
        end else begin
            stall = stall_therm;
        end
    end

    assign stalled = bus.rdy_in && (stall != '0);

    // Flush sequencer: next-state and outputs.
    always_comb begin
        state_nxt         = state_q;
        len_nxt           = len_q;
        first_nxt         = first_q;
        accept            = 1'b0;
        bus.flush_out     = '0;
        bus.flush_ack_out = 1'b0;

        if (state_q == FLUSH && bus.rdy_in) begin
            bus.flush_out     = FLUSH_BITS;
            bus.flush_ack_out = first_q;
        end

        // Nothing advances while the pipeline is frozen; a frozen FLUSH cycle
        // does not consume flush length.
        if (bus.rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (bus.flush_req_in && !blocked) begin
                        accept    = 1'b1;
                        state_nxt = FLUSH;
                        len_nxt   = LEN_W'(FLUSH_LEN - 1);
                        first_nxt = 1'b1;
                    end
                end
                FLUSH: begin
                    first_nxt = 1'b0;
                    if (len_q == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        len_nxt = len_q - LEN_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            len_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            len_q   <= len_nxt;
            first_q <= first_nxt;
        end
    end

    // Stall watchdog: counts consecutive stalled active cycles, saturating at the
    // limit. hang is set on the cycle the count reaches the limit and is visible
    // on the following cycle; only reset clears it.
    generate
        if (WDOG_LIMIT > 0) begin : g_wdog
            localparam int RUN_W = $clog2(WDOG_LIMIT + 1);
            localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WDOG_LIMIT);

            logic [RUN_W-1:0] run_q;
            logic [RUN_W-1:0] run_nxt;
            logic             hang_q;

            always_comb begin
                run_nxt = '0;
                if (stalled) begin
                    run_nxt = (run_q == RUN_LIM) ? run_q : run_q + RUN_W'(1);
                end
            end

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    run_q  <= '0;
                    hang_q <= 1'b0;
                end else if (bus.rdy_in) begin
                    run_q <= run_nxt;
                    if (run_nxt == RUN_LIM) begin
                        hang_q <= 1'b1;
                    end
                end
            end

            assign hang = hang_q;
        end else begin : g_no_wdog
            assign hang = 1'b0;
        end
    endgenerate

    // Performance counters. Clear wins over increment.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.cnt_clr_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (accept) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_out        = stall;
    assign bus.hang_out         = hang;
    assign bus.stall_cycles_out = stall_cnt_q;
    assign bus.flush_count_out  = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline stall/flush controller for the RISC-V core. It replaces the fixed six-bit combinational stall priority encoder with a controller that has a configurable stage count. It adds a registered flush sequencer with a req/ack handshake, a global-ready freeze, a stall watchdog and performance counters. It sits beside the pipeline and drives the stall and flush inputs of every pipeline register, from the PC register (stage 0) through the oldest stage (STAGES-1).

## Interface
- STAGES, 6: number of pipeline positions. Bit 0 is PC, 1 is IF, 2 is ID, 3 is EX, 4 is MEM, 5 is WB. Minimum 3.
- FLUSH_STAGE, 3: stage that raises flush requests (branch resolution). Range 1..STAGES-2.
- FLUSH_LEN, 1: cycles flush_out stays asserted per accepted flush. Minimum 1.
- WDOG_LIMIT, 1024: consecutive stalled cycles that set hang_out. 0 disables the watchdog.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_in  in  1  clock. All state is on the rising edge.
- rst_in  in  1  reset. Asynchronous and active-low: 0 resets.
- rdy_in  in  1  global ready. 0 freezes the pipeline.
- stallreq_in  in  STAGES  bit i: stage i requests a stall.
- flush_req_in  in  1  flush request from FLUSH_STAGE. Held until acknowledged.
- cnt_clr_in  in  1  synchronous clear of both counters.
- stall_out  out  STAGES  bit i = 1 holds stage i. 1 means stall.
- flush_out  out  STAGES  bit i = 1 squashes stage i. Only bits 0..FLUSH_STAGE-1 are ever set.
- flush_ack_out  out  1  one-cycle acknowledge of an accepted flush.
- hang_out  out  1  sticky watchdog flag.
- stall_cycles_out  out  CNT_W  cycles with stall_out ≠ 0. Saturating.
- flush_count_out  out  CNT_W  accepted flushes. Wraps modulo 2^CNT_W.

## Operation
- Mask: while the state is FLUSH, stallreq_in bits 0..FLUSH_STAGE-1 are ignored. Elsewhere the mask is all ones.
- Let k be the highest index with a masked request set. stall_out bits 0..k are 1 and all others are 0. No masked request gives stall_out = 0.
- rdy_in = 0 overrides everything: stall_out is all ones and flush_out is 0.
- While rdy_in = 0, the state, length counter, watchdog and counters hold their values.
- stall_out is combinational from its inputs and the current state. While rst_in = 0, stall_out = 0.
- There are two states, IDLE and FLUSH.
- IDLE to FLUSH happens when flush_req_in = 1, rdy_in = 1, and no stallreq_in bit above FLUSH_STAGE is set. This is the accept cycle.
- A request at FLUSH_STAGE itself does not block acceptance.
- A blocked request stays pending. The requester keeps it high.
- FLUSH asserts flush_out bits 0..FLUSH_STAGE-1 (registered) for FLUSH_LEN cycles. It then returns to IDLE.
- flush_ack_out is 1 only in the first FLUSH cycle. The requester drops flush_req_in in that cycle.
- flush_req_in is ignored while in FLUSH. A request that is high on return to IDLE is a new flush.
- Watchdog run counter:
  - Increments on each rdy_in = 1 cycle with stall_out ≠ 0.
  - Clears on a rdy_in = 1 cycle with stall_out = 0.
  - Saturates at WDOG_LIMIT.
  - When it reaches WDOG_LIMIT, hang_out goes to 1 and stays 1 until reset.
- stall_cycles_out increments on the same condition as the run counter and saturates at all ones.
- flush_count_out increments on each accept cycle.
- cnt_clr_in = 1 zeroes both counters in that cycle, taking priority over increment. It does not affect the watchdog or hang_out.

## Timing
- Reset values: state IDLE, flush_out 0, flush_ack_out 0, hang_out 0, both counters 0, run counter 0, stall_out 0.
- Stall path: 0 cycles, the same cycle as stallreq_in.
- Flush path: accept in cycle N.
  - flush_out and flush_ack_out are 1 in cycle N+1.
  - flush_out stays 1 through cycle N+FLUSH_LEN.
  - IDLE again at N+FLUSH_LEN+1.
  - flush_count_out shows the increment in N+1.
- rdy_in = 0 during FLUSH extends flush_out low time but not the number of flush_out cycles: the remaining length resumes when rdy_in returns.
- hang_out rises the cycle after the WDOG_LIMIT-th consecutive stalled cycle.
- Reset asserted mid-flush clears everything immediately and asynchronously. No ack is pending afterwards.

## Test plan
- Default parameters, stallreq_in = 6'b010000 (MEM) together with 6'b000100 -> stall_out = 6'b011111. Then only 6'b000010 -> 6'b000011. Then 0 -> 6'b000000.
- flush_req_in rising in cycle 10 with no stalls -> flush_ack_out and flush_out = 6'b000111 in cycle 11 only, and flush_count_out = 1.
- flush_req_in with stallreq_in[4] held for cycles 20–24 -> no ack until the cycle after 24 -> FLUSH in cycle 26.
- In FLUSH with FLUSH_LEN = 3, stallreq_in = 6'b000010 -> stall_out = 0. With stallreq_in = 6'b001000 -> stall_out = 6'b001111.
- WDOG_LIMIT = 8, stallreq_in[3] held -> hang_out = 1 after 8 stalled cycles and remains 1 after the stall drops. stall_cycles_out equals the stalled-cycle count. cnt_clr_in -> both counters 0 and hang_out still 1.
- rdy_in = 0 mid-FLUSH for 4 cycles, then rst_in pulsed low mid-FLUSH -> freeze: stall_out all ones and flush_out 0. Then all outputs return to their reset values immediately.
